// File: rtl/multiplex_display_pkg.sv
// Shared types and anode patterns for the multiplexed seven-segment driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multiplex_display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;
    typedef logic [1:0] digit_idx_t;

    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;
    localparam logic [3:0] AN_OFF = 4'b1111;

    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        logic [3:0] an;
        an = AN_D0;
        case (idx)
            2'd0:    an = AN_D0;
            2'd1:    an = AN_D1;
            2'd2:    an = AN_D2;
            default: an = AN_D3;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divider: one-cycle tick every contar clocks (on cnt == contar-1).
// Latency: tick is combinational from the counter register.
// Backpressure: none; always counts.
module refresh_prescaler #(
    parameter int contar = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (contar > 1) ? $clog2(contar) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(contar - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/multiplex_display.sv
// 4-digit seven-segment mux; optional leading-zero blanking via MULTIPLEX_DISPLAY_BLANK_EN.
// Latency: outputs combinational from the digit index and digit inputs.
// Backpressure: none; rotates every contar cycles unconditionally.
module multiplex_display
    import multiplex_display_pkg::*;
#(
    parameter int contar = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    output logic [3:0] bcd_value,
    output logic [3:0] segmento_activo
);

    logic       tick;
    digit_idx_t pantalla_activa;
    logic       blank;

    refresh_prescaler #(.contar(contar)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pantalla_activa <= '0;
        end else if (tick) begin
            pantalla_activa <= pantalla_activa + digit_idx_t'(1);
        end
    end

    always_comb begin
        bcd_value = digit0;
        case (pantalla_activa)
            2'd0:    bcd_value = digit0;
            2'd1:    bcd_value = digit1;
            2'd2:    bcd_value = digit2;
            default: bcd_value = digit3;
        endcase
    end

`ifdef MULTIPLEX_DISPLAY_BLANK_EN
    // A digit is dark only when it and every more-significant digit are zero.
    always_comb begin
        blank = 1'b0;
        case (pantalla_activa)
            2'd3:    blank = (digit3 == 4'd0);
            2'd2:    blank = (digit3 == 4'd0) && (digit2 == 4'd0);
            2'd1:    blank = (digit3 == 4'd0) && (digit2 == 4'd0) && (digit1 == 4'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign segmento_activo = blank ? AN_OFF : anode_for(pantalla_activa);

endmodule

// File: tb/tb_multiplex_display.sv
// Bench for multiplex_display: contar=10 instance for slot timing, contar=1 instance for per-cycle rotation.
module tb_multiplex_display;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
    } out_t;

    typedef struct packed {
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic [3:0] an;
        logic [3:0] bcd;
    } vec_t;

    logic       clk;
    logic       rst, rst1;
    logic [3:0] a0, a1, a2, a3;
    logic [3:0] b0, b1, b2, b3;
    logic [3:0] bcd_a, seg_a, bcd_b, seg_b;

    int   errors = 0;
    int   checks = 0;
    out_t sb[$];

    multiplex_display #(.contar(10)) dut (
        .clk(clk), .rst(rst),
        .digit0(a0), .digit1(a1), .digit2(a2), .digit3(a3),
        .bcd_value(bcd_a), .segmento_activo(seg_a)
    );

    multiplex_display #(.contar(1)) dut1 (
        .clk(clk), .rst(rst1),
        .digit0(b0), .digit1(b1), .digit2(b2), .digit3(b3),
        .bcd_value(bcd_b), .segmento_activo(seg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t exp_out(input int slot, input logic [3:0] d0, d1, d2, d3);
        out_t o;
        logic [3:0] onehot;
        onehot = 4'b0001 << slot;
        o.an = ~onehot;
        case (slot)
            0:       o.bcd = d0;
            1:       o.bcd = d1;
            2:       o.bcd = d2;
            default: o.bcd = d3;
        endcase
`ifdef MULTIPLEX_DISPLAY_BLANK_EN
        if ((slot == 3 && d3 == 0) || (slot == 2 && d3 == 0 && d2 == 0) ||
            (slot == 1 && d3 == 0 && d2 == 0 && d1 == 0))
            o.an = 4'b1111;
`endif
        return o;
    endfunction

    task automatic push_exp(input out_t e);
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [3:0] an, input logic [3:0] bcd);
        out_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got seg=%b bcd=%0d", name, an, bcd);
        end else begin
            e = sb.pop_front();
            if (an !== e.an || bcd !== e.bcd) begin
                errors++;
                $display("FAIL %s: got seg=%b bcd=%0d, expected seg=%b bcd=%0d",
                         name, an, bcd, e.an, e.bcd);
            end
        end
    endtask

    // Sample k after the last reset edge of the contar=10 instance sits in slot (k/10)%4.
    task automatic run_slots(input string name, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            @(posedge clk); #2;
            push_exp(exp_out((k / 10) % 4, a0, a1, a2, a3));
            check($sformatf("%s_k%0d", name, k), seg_a, bcd_a);
        end
    endtask

    task automatic step1(input string name, input int slot);
        @(posedge clk); #2;
        push_exp(exp_out(slot, b0, b1, b2, b3));
        check(name, seg_b, bcd_b);
    endtask

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{d0: 4'd1,  d1: 4'd2,  d2: 4'd3,  d3: 4'd4,  an: 4'b1101, bcd: 4'd2};
        tbl[1] = '{d0: 4'd5,  d1: 4'd6,  d2: 4'd7,  d3: 4'd8,  an: 4'b1011, bcd: 4'd7};
        tbl[2] = '{d0: 4'd9,  d1: 4'd0,  d2: 4'd1,  d3: 4'd2,  an: 4'b0111, bcd: 4'd2};
        tbl[3] = '{d0: 4'd10, d1: 4'd11, d2: 4'd12, d3: 4'd13, an: 4'b1110, bcd: 4'd10};
        tbl[4] = '{d0: 4'd15, d1: 4'd14, d2: 4'd13, d3: 4'd12, an: 4'b1101, bcd: 4'd14};
        tbl[5] = '{d0: 4'd0,  d1: 4'd0,  d2: 4'd15, d3: 4'd1,  an: 4'b1011, bcd: 4'd15};
        tbl[6] = '{d0: 4'd3,  d1: 4'd3,  d2: 4'd3,  d3: 4'd9,  an: 4'b0111, bcd: 4'd9};
        tbl[7] = '{d0: 4'd8,  d1: 4'd7,  d2: 4'd6,  d3: 4'd5,  an: 4'b1110, bcd: 4'd8};

        rst = 1'b1; rst1 = 1'b1;
        a0 = 4'd1; a1 = 4'd2; a2 = 4'd3; a3 = 4'd4;
        b0 = 4'd0; b1 = 4'd0; b2 = 4'd0; b3 = 4'd1;

        // Reset held two cycles: slot 0 throughout.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            push_exp('{an: 4'b1110, bcd: 4'd1});
            check($sformatf("reset_hold_%0d", i), seg_a, bcd_a);
        end
        rst = 1'b0;

        // Full rotation plus wrap, each slot exactly 10 cycles.
        run_slots("rotate", 1, 44);
        run_slots("to_slot2", 45, 62);

        // Digit change mid-slot shows up without waiting for an edge.
        a2 = 4'd9;
        #1;
        push_exp('{an: 4'b1011, bcd: 4'd9});
        check("digit2_change_same_cycle", seg_a, bcd_a);
        run_slots("slot2_len", 63, 74);

        // Reset in slot 3 at cnt=4, then slot 0 must last a full 10 cycles.
        rst = 1'b1;
        @(posedge clk); #2;
        push_exp('{an: 4'b1110, bcd: 4'd1});
        check("mid_rotation_reset", seg_a, bcd_a);
        rst = 1'b0;
        run_slots("post_reset", 1, 11);

        // contar=1: index advances every edge.
        @(posedge clk); #2;
        push_exp('{an: 4'b1110, bcd: 4'd0});
        check("c1_reset", seg_b, bcd_b);
        rst1 = 1'b0;
        foreach (tbl[i]) begin
            b0 = tbl[i].d0; b1 = tbl[i].d1; b2 = tbl[i].d2; b3 = tbl[i].d3;
            @(posedge clk); #2;
            push_exp('{an: tbl[i].an, bcd: tbl[i].bcd});
            check($sformatf("c1_vec%0d", i), seg_b, bcd_b);
        end

        // Leading-zero patterns (blanked only when the macro is defined).
        b0 = 4'd7; b1 = 4'd5; b2 = 4'd0; b3 = 4'd0;
        rst1 = 1'b1;
        step1("lz_0057_reset", 0);
        rst1 = 1'b0;
        for (int s = 1; s < 5; s++) step1($sformatf("lz_0057_slot%0d", s % 4), s % 4);
        b0 = 4'd0; b1 = 4'd0;
        for (int s = 1; s < 5; s++) step1($sformatf("lz_0000_slot%0d", s % 4), s % 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
